mem_stage_responder: RTL and testbench

//  Memory-stage responder for the pipelined RV32 core. Services the load/store request

---
 rtl/mem_stage_responder_pkg.sv | 22 ++
 rtl/mem_stage_responder_mem_wait_counter.sv | 31 +++
 rtl/mem_stage_responder_register.sv | 23 ++
 rtl/mem_stage_responder.sv | 127 ++++++++++++
 tb/tb_mem_stage_responder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_responder_pkg.sv
// Shared definitions for the memory-stage responder: FSM encoding,
// load-select code and the default ack timeout.
package mem_stage_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ResultSrcM value that marks a load in the M stage
  localparam logic [1:0] RESULTSRC_MEM = 2'b01;

  // Cycles spent waiting for mem_ack before the access is abandoned
  localparam int DEFAULT_TIMEOUT = 16;

  // A word access is misaligned when either low address bit is set
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_responder_mem_wait_counter.sv
// Wait counter for an outstanding memory request: synchronous clear,
// count enable and a flag marking the last permitted wait cycle.
module mem_wait_counter #(
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] count;

  // Clear has priority over counting so every request starts from zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= {CW{1'b0}};
    end else if (clr) begin
      count <= {CW{1'b0}};
    end else if (en) begin
      count <= count + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_responder_register.sv
// Generic enabled holding register with synchronous active-low reset.
module Register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled, otherwise hold; reset clears the contents
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= {WIDTH{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/mem_stage_responder.sv
// Memory-stage responder: turns the M-stage load/store into a req/ack
// access on the data memory, stalls the pipeline while it is outstanding
// and returns load data (or an error pulse) in a single DONE cycle.
module mem_stage_responder
  import mem_stage_responder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic             StallM,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             MemErrM,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  state_t           state;
  logic             access;
  logic             misaligned;
  logic             hold_en;
  logic             we_q;
  logic             err_q;
  logic             timeout_tc;
  logic [WIDTH-3:0] addr_word_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;

  assign access     = MemWriteM | (ResultSrcM == RESULTSRC_MEM);
  assign misaligned = is_misaligned(ALUResultM[1:0]);

  // Request fields track the M stage while idle and freeze once an access starts
  assign hold_en = (state == ST_IDLE);

  Register #(.WIDTH(WIDTH-2)) u_addr_reg (
    .clk (clk),
    .rst (rst),
    .en  (hold_en),
    .d   (ALUResultM[WIDTH-1:2]),
    .q   (addr_word_q)
  );

  Register #(.WIDTH(WIDTH)) u_wdata_reg (
    .clk (clk),
    .rst (rst),
    .en  (hold_en),
    .d   (WriteDataM),
    .q   (wdata_q)
  );

  Register #(.WIDTH(1)) u_we_reg (
    .clk (clk),
    .rst (rst),
    .en  (hold_en),
    .d   (MemWriteM),
    .q   (we_q)
  );

  mem_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_REQ),
    .en  (state == ST_REQ),
    .tc  (timeout_tc)
  );

  // Access sequencer: start, wait for ack or timeout, then one result cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      err_q   <= 1'b0;
      rdata_q <= {WIDTH{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            err_q   <= misaligned;
            rdata_q <= {WIDTH{1'b0}};
            state   <= misaligned ? ST_DONE : ST_REQ;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (!we_q) begin
              rdata_q <= mem_rdata;
            end
            state <= ST_DONE;
          end else if (timeout_tc) begin
            err_q <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_DONE: begin
          err_q <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          err_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The stall must rise in the very cycle the access is first seen
  assign StallM    = (state == ST_REQ) | ((state == ST_IDLE) & access);
  assign mem_req   = (state == ST_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_word_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign ReadDataM = rdata_q;
  assign MemErrM   = (state == ST_DONE) & err_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Self-checking bench for mem_stage_responder: per-cycle expectations
// derived from the latency/outcome rules, plus literal spot checks.
module tb_mem_stage_responder;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             MemWriteM = 1'b0;
  logic [1:0]       ResultSrcM = 2'b00;
  logic [WIDTH-1:0] ALUResultM = 32'd0;
  logic [WIDTH-1:0] WriteDataM = 32'd0;
  logic             StallM;
  logic [WIDTH-1:0] ReadDataM;
  logic             MemErrM;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack = 1'b0;
  logic [WIDTH-1:0] mem_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_stage_responder #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .MemErrM    (MemErrM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations set by the driver
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic        exp_err = 1'b0, exp_done = 1'b0;
  logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0, exp_rd = 32'd0;

  // Observation totals for literal checks
  int          stall_total = 0;
  int          req_total = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] last_rd = 32'd0;
  logic        last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Compare process: DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("StallM", {31'd0, StallM}, {31'd0, exp_stall});
      check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      check("MemErrM", {31'd0, MemErrM}, {31'd0, exp_err});
      if (exp_req) begin
        check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        check("mem_addr", mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
      if (exp_done) check("ReadDataM", ReadDataM, exp_rd);
    end
  end

  // Monitor: totals of stall/request cycles and the result seen when a stall ends
  always @(negedge clk) begin
    if (StallM) stall_total <= stall_total + 1;
    if (mem_req) req_total <= req_total + 1;
    if (!StallM && stall_prev) begin
      last_rd  <= ReadDataM;
      last_err <= MemErrM;
    end
    stall_prev <= StallM;
  end

  // One M-stage instruction: ack_delay = REQ cycle carrying the ack (0 = never)
  task automatic run_txn(input logic we, input logic [1:0] rsrc, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_delay, input logic [31:0] rdata);
    logic access, mis, acked, err, in_req;
    int   n_req;
    access = we | (rsrc == 2'b01);
    mis    = (addr[1:0] != 2'b00);
    acked  = (ack_delay >= 1) && (ack_delay <= TIMEOUT);
    err    = mis || !acked;
    n_req  = mis ? 0 : (acked ? ack_delay : TIMEOUT);
    chk_en = 1'b1;
    MemWriteM = we; ResultSrcM = rsrc; ALUResultM = addr; WriteDataM = wdata;
    if (!access) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_done = 1'b0;
      @(posedge clk); #1;
    end else begin
      for (int k = 0; k <= n_req + 1; k++) begin
        in_req = (k >= 1) && (k <= n_req);
        if (in_req && k == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else if (in_req) begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end else begin
          mem_ack = ($urandom_range(0, 2) == 0); mem_rdata = $urandom;
        end
        exp_stall = (k <= n_req);
        exp_req   = in_req;
        exp_we    = we;
        exp_addr  = {addr[31:2], 2'b00};
        exp_wdata = wdata;
        exp_done  = (k == n_req + 1);
        exp_err   = exp_done && err;
        exp_rd    = (!we && !err) ? rdata : 32'd0;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int s0, r0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_StallM", {31'd0, StallM}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_MemErrM", {31'd0, MemErrM}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_ReadDataM", ReadDataM, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;

    // Load from 0x10, ack in third REQ cycle
    s0 = stall_total; r0 = req_total;
    run_txn(1'b0, 2'b01, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF);
    check("t1_stall_cycles", stall_total - s0, 32'd4);
    check("t1_req_cycles", req_total - r0, 32'd3);
    check("t1_rdata", last_rd, 32'hDEAD_BEEF);
    check("t1_err", {31'd0, last_err}, 32'd0);

    // Store to 0x20, ack in first REQ cycle
    s0 = stall_total; r0 = req_total;
    run_txn(1'b1, 2'b00, 32'h0000_0020, 32'h1234_5678, 1, 32'hFFFF_FFFF);
    check("t2_stall_cycles", stall_total - s0, 32'd2);
    check("t2_req_cycles", req_total - r0, 32'd1);
    check("t2_rdata", last_rd, 32'd0);

    // Load that never gets an ack
    s0 = stall_total; r0 = req_total;
    run_txn(1'b0, 2'b01, 32'h0000_0030, 32'h0, 0, 32'h0);
    check("t3_req_cycles", req_total - r0, 32'd16);
    check("t3_stall_cycles", stall_total - s0, 32'd17);
    check("t3_err", {31'd0, last_err}, 32'd1);
    check("t3_rdata", last_rd, 32'd0);

    // Misaligned store
    s0 = stall_total; r0 = req_total;
    run_txn(1'b1, 2'b00, 32'h0000_0022, 32'hAAAA_5555, 1, 32'h0);
    check("t4_req_cycles", req_total - r0, 32'd0);
    check("t4_stall_cycles", stall_total - s0, 32'd1);
    check("t4_err", {31'd0, last_err}, 32'd1);

    // Reset in the middle of an outstanding load
    chk_en = 1'b0;
    MemWriteM = 1'b0; ResultSrcM = 2'b01; ALUResultM = 32'h0000_0080; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_req_before_rst", {31'd0, mem_req}, 32'd1);
    rst = 1'b0; ResultSrcM = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    check("t5_mem_req", {31'd0, mem_req}, 32'd0);
    check("t5_StallM", {31'd0, StallM}, 32'd0);
    check("t5_mem_addr", mem_addr, 32'd0);
    run_txn(1'b0, 2'b01, 32'h0000_0040, 32'h0, 2, 32'hCAFE_F00D);
    check("t5_rdata", last_rd, 32'hCAFE_F00D);

    // Back-to-back load and store with stray acks on bubbles
    s0 = stall_total; r0 = req_total;
    run_txn(1'b0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
    run_txn(1'b0, 2'b01, 32'h0000_0100, 32'h0, 2, 32'h0BAD_F00D);
    run_txn(1'b1, 2'b01, 32'h0000_0104, 32'h7777_8888, 1, 32'h1111_2222);
    run_txn(1'b0, 2'b11, 32'h0, 32'h0, 0, 32'h0);
    check("t6_req_cycles", req_total - r0, 32'd3);
    check("t6_stall_cycles", stall_total - s0, 32'd5);

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      logic        r_we;
      logic [1:0]  r_src;
      logic [31:0] r_addr;
      r_we   = ($urandom_range(0, 2) == 0);
      r_src  = 2'($urandom_range(0, 3));
      r_addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
      run_txn(r_we, r_src, r_addr, $urandom, $urandom_range(0, 20), $urandom);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
